// File: rtl/cu_fsm_param_pkg.sv
// Shared definitions for the parametrised multi-cycle control unit:
// instruction types, one-hot state codes and instruction field positions.
package cu_fsm_param_pkg;

  localparam int unsigned OPC_WIDTH  = 4;
  localparam int unsigned TYPE_WIDTH = 2;
  localparam logic [OPC_WIDTH-1:0] OPC_RESET = 4'b1111;

  typedef enum logic [TYPE_WIDTH-1:0] {
    T_NOP   = 2'b00,
    T_STD   = 2'b01,
    T_LOAD  = 2'b10,
    T_STORE = 2'b11
  } instr_type_e;

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_DECODE  = 5'b00010,
    S_EXECUTE = 5'b00100,
    S_MEM     = 5'b01000,
    S_WB      = 5'b10000
  } state_e;

  // Field LSB positions; word is {type, rd, rs1, rs2, offset, opcode}
  function automatic int unsigned off_lsb();
    return OPC_WIDTH;
  endfunction

  function automatic int unsigned rs2_lsb(input int unsigned ow);
    return OPC_WIDTH + ow;
  endfunction

  function automatic int unsigned rs1_lsb(input int unsigned rb, input int unsigned ow);
    return OPC_WIDTH + ow + rb;
  endfunction

  function automatic int unsigned rd_lsb(input int unsigned rb, input int unsigned ow);
    return OPC_WIDTH + ow + 2 * rb;
  endfunction

  function automatic int unsigned type_lsb(input int unsigned rb, input int unsigned ow);
    return OPC_WIDTH + ow + 3 * rb;
  endfunction

  function automatic int unsigned instr_width(input int unsigned rb, input int unsigned ow);
    return TYPE_WIDTH + 3 * rb + ow + OPC_WIDTH;
  endfunction

endpackage

// File: rtl/cu_regfile.sv
// Register file: two combinational read ports, one synchronous write port,
// each register resets to its own index.
module cu_regfile
  import cu_fsm_param_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned REG_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_BITS-1:0]   i_raddr1,
  input  logic [REG_BITS-1:0]   i_raddr2,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic [DATA_WIDTH-1:0] o_rdata2,
  input  logic                  i_we,
  input  logic [REG_BITS-1:0]   i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata
);

  localparam int unsigned NUM_REGS = 2 ** REG_BITS;

  logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_mem[g] <= DATA_WIDTH'(g);
      end else if (i_we && (i_waddr == REG_BITS'(g))) begin
        r_mem[g] <= i_wdata;
      end
    end
  end

  assign o_rdata1 = r_mem[i_raddr1];
  assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/cu_fsm_param.sv
// Multi-cycle control unit: accepts instructions over valid/ready, sequences
// decode/execute/memory/writeback and drives the ALU and data-memory controls.
module cu_fsm_param
  import cu_fsm_param_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned REG_BITS     = 2,
  parameter int unsigned OFFSET_WIDTH = 8,
  parameter int unsigned MEM_TIMEOUT  = 16,
  localparam int unsigned INSTR_WIDTH = instr_width(REG_BITS, OFFSET_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [DATA_WIDTH-1:0]  result2,
  input  logic                   mem_ack,
  output logic                   mem_req,
  output logic [DATA_WIDTH-1:0]  operand1,
  output logic [DATA_WIDTH-1:0]  operand2,
  output logic [DATA_WIDTH-1:0]  offset,
  output logic [OPC_WIDTH-1:0]   opcode,
  output logic                   sel1,
  output logic                   sel3,
  output logic                   w_r,
  output logic                   retired,
  output logic                   err
);

  localparam int unsigned OFF_LSB  = off_lsb();
  localparam int unsigned RS2_LSB  = rs2_lsb(OFFSET_WIDTH);
  localparam int unsigned RS1_LSB  = rs1_lsb(REG_BITS, OFFSET_WIDTH);
  localparam int unsigned RD_LSB   = rd_lsb(REG_BITS, OFFSET_WIDTH);
  localparam int unsigned TYPE_LSB = type_lsb(REG_BITS, OFFSET_WIDTH);
  localparam int unsigned WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e                  r_state, w_state_nxt;
  logic [INSTR_WIDTH-1:0]  r_instr, w_instr_nxt;
  logic [WAIT_W-1:0]       r_wait, w_wait_nxt;
  logic [DATA_WIDTH-1:0]   r_operand1, w_op1_nxt;
  logic [DATA_WIDTH-1:0]   r_operand2, w_op2_nxt;
  logic [DATA_WIDTH-1:0]   r_offset, w_off_nxt;
  logic [OPC_WIDTH-1:0]    r_opcode, w_opc_nxt;
  logic                    r_sel1, w_sel1_nxt;
  logic                    r_sel3, w_sel3_nxt;
  logic                    r_w_r, w_wr_nxt;
  logic                    r_mem_req, w_mem_req_nxt;
  logic                    r_retired, w_retired_nxt;
  logic                    r_err, w_err_nxt;
  logic                    r_ready, w_ready_nxt;
  logic                    w_rf_we;

  instr_type_e             w_type, w_in_type;
  logic [REG_BITS-1:0]     w_rd, w_rs1, w_rs2, w_raddr2;
  logic [OFFSET_WIDTH-1:0] w_off;
  logic [OPC_WIDTH-1:0]    w_opc;
  logic [DATA_WIDTH-1:0]   w_rdata1, w_rdata2;

  assign w_in_type = instr_type_e'(instr[TYPE_LSB +: TYPE_WIDTH]);
  assign w_type    = instr_type_e'(r_instr[TYPE_LSB +: TYPE_WIDTH]);
  assign w_rd      = r_instr[RD_LSB +: REG_BITS];
  assign w_rs1     = r_instr[RS1_LSB +: REG_BITS];
  assign w_rs2     = r_instr[RS2_LSB +: REG_BITS];
  assign w_off     = r_instr[OFF_LSB +: OFFSET_WIDTH];
  assign w_opc     = r_instr[0 +: OPC_WIDTH];
  // Memory ops present R[rd] on operand2 as the store data / address base
  assign w_raddr2  = (w_type == T_STD) ? w_rs2 : w_rd;

  cu_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_BITS   (REG_BITS)
  ) u_rf (
    .clk      (clk),
    .rst_n    (rst),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_raddr2),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2),
    .i_we     (w_rf_we),
    .i_waddr  (w_rd),
    .i_wdata  (result2)
  );

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_instr_nxt   = r_instr;
    w_wait_nxt    = r_wait;
    w_op1_nxt     = r_operand1;
    w_op2_nxt     = r_operand2;
    w_off_nxt     = r_offset;
    w_opc_nxt     = r_opcode;
    w_sel1_nxt    = r_sel1;
    w_sel3_nxt    = r_sel3;
    w_retired_nxt = 1'b0;
    w_err_nxt     = 1'b0;
    w_rf_we       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (instr_valid) begin
          w_instr_nxt = instr;
          if (w_in_type != T_NOP) w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        w_op1_nxt   = w_rdata1;
        w_op2_nxt   = w_rdata2;
        w_off_nxt   = DATA_WIDTH'(w_off);
        w_opc_nxt   = w_opc;
        w_sel1_nxt  = (w_type != T_LOAD);
        w_sel3_nxt  = (w_type != T_STD);
        w_state_nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        w_wait_nxt  = '0;
        w_state_nxt = (w_type == T_STD) ? S_WB : S_MEM;
      end
      S_MEM: begin
        // An ack on the expiry cycle still completes the access
        if (mem_ack) begin
          if (w_type == T_LOAD) begin
            w_state_nxt = S_WB;
          end else begin
            w_state_nxt   = S_IDLE;
            w_retired_nxt = 1'b1;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end
      S_WB: begin
        w_rf_we       = 1'b1;
        w_retired_nxt = 1'b1;
        w_state_nxt   = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_mem_req_nxt = (w_state_nxt == S_MEM);
    w_wr_nxt      = w_mem_req_nxt && (w_type == T_STORE);
    w_ready_nxt   = (w_state_nxt == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_instr    <= '0;
      r_wait     <= '0;
      r_operand1 <= '0;
      r_operand2 <= '0;
      r_offset   <= '0;
      r_opcode   <= OPC_RESET;
      r_sel1     <= 1'b0;
      r_sel3     <= 1'b0;
      r_w_r      <= 1'b0;
      r_mem_req  <= 1'b0;
      r_retired  <= 1'b0;
      r_err      <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_instr    <= w_instr_nxt;
      r_wait     <= w_wait_nxt;
      r_operand1 <= w_op1_nxt;
      r_operand2 <= w_op2_nxt;
      r_offset   <= w_off_nxt;
      r_opcode   <= w_opc_nxt;
      r_sel1     <= w_sel1_nxt;
      r_sel3     <= w_sel3_nxt;
      r_w_r      <= w_wr_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_retired  <= w_retired_nxt;
      r_err      <= w_err_nxt;
      r_ready    <= w_ready_nxt;
    end
  end

  assign instr_ready = r_ready;
  assign mem_req     = r_mem_req;
  assign operand1    = r_operand1;
  assign operand2    = r_operand2;
  assign offset      = r_offset;
  assign opcode      = r_opcode;
  assign sel1        = r_sel1;
  assign sel3        = r_sel3;
  assign w_r         = r_w_r;
  assign retired     = r_retired;
  assign err         = r_err;

endmodule

// File: tb/tb_cu_fsm_param.sv
// Directed table-driven bench for cu_fsm_param (MEM_TIMEOUT overridden to 4).
module tb_cu_fsm_param;

  localparam int unsigned DW = 8;
  localparam int unsigned RB = 2;
  localparam int unsigned OW = 8;
  localparam int unsigned TO = 4;
  localparam int unsigned IW = 2 + 3 * RB + OW + 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] result2;
  logic          mem_ack;
  logic          mem_req;
  logic [DW-1:0] operand1, operand2, offset;
  logic [3:0]    opcode;
  logic          sel1, sel3, w_r, retired, err;

  always #5 clk = ~clk;

  cu_fsm_param #(
    .DATA_WIDTH   (DW),
    .REG_BITS     (RB),
    .OFFSET_WIDTH (OW),
    .MEM_TIMEOUT  (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .result2     (result2),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .operand1    (operand1),
    .operand2    (operand2),
    .offset      (offset),
    .opcode      (opcode),
    .sel1        (sel1),
    .sel3        (sel3),
    .w_r         (w_r),
    .retired     (retired),
    .err         (err)
  );

  // ack_dly: MEM_ACCESS cycle index carrying mem_ack (-1 = never);
  // e_ret/e_err: cycle after accept of the pulse (-1 = none); e_r = {R3,R2,R1,R0}
  typedef struct packed {
    logic [1:0]  ityp;
    logic [1:0]  rd;
    logic [1:0]  rs1;
    logic [1:0]  rs2;
    logic [7:0]  off;
    logic [3:0]  opc;
    int          ack_dly;
    logic [7:0]  res;
    logic [7:0]  e_op1;
    logic [7:0]  e_op2;
    logic [7:0]  e_off;
    logic [3:0]  e_opc;
    logic        e_sel1;
    logic        e_sel3;
    int          e_ret;
    int          e_err;
    int          e_req;
    int          e_wr;
    logic [31:0] e_r;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] regs();
    return {dut.u_rf.r_mem[3], dut.u_rf.r_mem[2], dut.u_rf.r_mem[1], dut.u_rf.r_mem[0]};
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int ret_cyc, err_cyc, n_ret, n_err, n_req, n_wr, guard;
    logic rdy1;
    logic [7:0] op1, op2, off;
    logic [3:0] opc;
    logic s1, s3;
    string p;
    p = $sformatf("v%0d", idx);
    ret_cyc = -1; err_cyc = -1; n_ret = 0; n_err = 0; n_req = 0; n_wr = 0; guard = 0;
    rdy1 = 1'b0; op1 = '0; op2 = '0; off = '0; opc = '0; s1 = 1'b0; s3 = 1'b0;
    @(negedge clk);
    while (!instr_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({p, ".ready_pre"}, 32'(instr_ready), 32'd1);
    instr       = {v.ityp, v.rd, v.rs1, v.rs2, v.off, v.opc};
    instr_valid = 1'b1;
    result2     = v.res;
    mem_ack     = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      if (c == 1) rdy1 = instr_ready;
      if (c == 2) begin
        op1 = operand1; op2 = operand2; off = offset; opc = opcode; s1 = sel1; s3 = sel3;
      end
      if (retired) begin n_ret++; if (ret_cyc < 0) ret_cyc = c; end
      if (err)     begin n_err++; if (err_cyc < 0) err_cyc = c; end
      if (mem_req) n_req++;
      if (w_r)     n_wr++;
      mem_ack = (v.ack_dly >= 0) && (c == 3 + v.ack_dly);
    end
    mem_ack = 1'b0;
    chk({p, ".ready_c1"}, 32'(rdy1), (v.ityp == 2'd0) ? 32'd1 : 32'd0);
    chk({p, ".operand1"}, 32'(op1), 32'(v.e_op1));
    chk({p, ".operand2"}, 32'(op2), 32'(v.e_op2));
    chk({p, ".offset"},   32'(off), 32'(v.e_off));
    chk({p, ".opcode"},   32'(opc), 32'(v.e_opc));
    chk({p, ".sel1"},     32'(s1),  32'(v.e_sel1));
    chk({p, ".sel3"},     32'(s3),  32'(v.e_sel3));
    chk({p, ".ret_cyc"},  32'(ret_cyc), 32'(v.e_ret));
    chk({p, ".ret_cnt"},  32'(n_ret), (v.e_ret < 0) ? 32'd0 : 32'd1);
    chk({p, ".err_cyc"},  32'(err_cyc), 32'(v.e_err));
    chk({p, ".err_cnt"},  32'(n_err), (v.e_err < 0) ? 32'd0 : 32'd1);
    chk({p, ".req_cyc"},  32'(n_req), 32'(v.e_req));
    chk({p, ".wr_cyc"},   32'(n_wr),  32'(v.e_wr));
    chk({p, ".regs"},     regs(), v.e_r);
    chk({p, ".ready_end"}, 32'(instr_ready), 32'd1);
  endtask

  vec_t tbl [9];
  vec_t vp;

  initial begin
    //         ty    rd    rs1   rs2   off    opc  ack  res    op1    op2    off    opc  s1   s3  ret err req wr  regs
    tbl[0] = '{2'd0, 2'd0, 2'd0, 2'd0, 8'h00, 4'h0, -1, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF, 1'b0, 1'b0, -1, -1, 0, 0, 32'h03020100};
    tbl[1] = '{2'd1, 2'd1, 2'd2, 2'd3, 8'h05, 4'h2, -1, 8'h05, 8'h02, 8'h03, 8'h05, 4'h2, 1'b1, 1'b0,  4, -1, 0, 0, 32'h03020500};
    tbl[2] = '{2'd1, 2'd0, 2'd1, 2'd1, 8'h00, 4'h3, -1, 8'h7E, 8'h05, 8'h05, 8'h00, 4'h3, 1'b1, 1'b0,  4, -1, 0, 0, 32'h0302057E};
    tbl[3] = '{2'd2, 2'd2, 2'd1, 2'd0, 8'h10, 4'h0,  3, 8'hAA, 8'h05, 8'h02, 8'h10, 4'h0, 1'b0, 1'b1,  8, -1, 4, 0, 32'h03AA057E};
    tbl[4] = '{2'd3, 2'd3, 2'd0, 2'd0, 8'h22, 4'h1,  0, 8'h55, 8'h7E, 8'h03, 8'h22, 4'h1, 1'b1, 1'b1,  4, -1, 1, 1, 32'h03AA057E};
    tbl[5] = '{2'd2, 2'd1, 2'd2, 2'd0, 8'hFF, 4'h4, -1, 8'h33, 8'hAA, 8'h05, 8'hFF, 4'h4, 1'b0, 1'b1, -1,  7, 4, 0, 32'h03AA057E};
    tbl[6] = '{2'd3, 2'd2, 2'd3, 2'd1, 8'h01, 4'h6,  2, 8'h44, 8'h03, 8'hAA, 8'h01, 4'h6, 1'b1, 1'b1,  6, -1, 3, 3, 32'h03AA057E};
    tbl[7] = '{2'd1, 2'd3, 2'd2, 2'd0, 8'h44, 4'h9, -1, 8'h11, 8'hAA, 8'h7E, 8'h44, 4'h9, 1'b1, 1'b0,  4, -1, 0, 0, 32'h11AA057E};
    tbl[8] = '{2'd0, 2'd1, 2'd1, 2'd1, 8'hCC, 4'h7, -1, 8'h00, 8'hAA, 8'h7E, 8'h44, 4'h9, 1'b1, 1'b0, -1, -1, 0, 0, 32'h11AA057E};
    vp     = '{2'd1, 2'd0, 2'd3, 2'd2, 8'h01, 4'h5, -1, 8'h99, 8'h03, 8'h02, 8'h01, 4'h5, 1'b1, 1'b0,  4, -1, 0, 0, 32'h03020199};

    rst = 1'b0; instr = '0; instr_valid = 1'b0; result2 = '0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.ready",   32'(instr_ready), 32'd1);
    chk("rst.opcode",  32'(opcode), 32'hF);
    chk("rst.ops",     {8'h00, operand1, operand2, offset}, 32'd0);
    chk("rst.ctl",     {26'd0, sel1, sel3, w_r, mem_req, retired, err}, 32'd0);
    chk("rst.regs",    regs(), 32'h03020100);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(i, tbl[i]);

    // Reset asserted during a storeR that is waiting in MEM_ACCESS
    @(negedge clk);
    instr = {2'd3, 2'd3, 2'd0, 2'd0, 8'h00, 4'h1};
    instr_valid = 1'b1;
    mem_ack = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      instr_valid = 1'b0;
    end
    chk("mrst.req_before", 32'(mem_req), 32'd1);
    chk("mrst.wr_before",  32'(w_r), 32'd1);
    rst = 1'b0;
    #1;
    chk("mrst.req",    32'(mem_req), 32'd0);
    chk("mrst.wr",     32'(w_r), 32'd0);
    chk("mrst.ready",  32'(instr_ready), 32'd1);
    chk("mrst.ops",    {8'h00, operand1, operand2, offset}, 32'd0);
    chk("mrst.opcode", 32'(opcode), 32'hF);
    chk("mrst.sel",    {30'd0, sel1, sel3}, 32'd0);
    chk("mrst.regs",   regs(), 32'h03020100);
    @(negedge clk);
    rst = 1'b1;
    run_vec(9, vp);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cu_fsm_param.md
Name: cu_fsm_param

Overview:
Parametrised multi-cycle control unit for the simple CPU. It generalises register count, data width and offset width. It adds a valid/ready instruction handshake, a memory request/acknowledge wait with timeout, and complete storeR sequencing. It sits between the instruction source and the ALU/data-memory datapath, driving operands, offset, opcode and the datapath mux selects.

Parameters:
DATA_WIDTH, 8, datapath and register width
REG_BITS, 2, register index width; NUM_REGS = 2**REG_BITS
OFFSET_WIDTH, 8, immediate offset width (zero-extended or truncated to DATA_WIDTH)
MEM_TIMEOUT, 16, maximum cycles to wait for mem_ack (must be ≥1)
INSTR_WIDTH, derived: 2 + 3*REG_BITS + OFFSET_WIDTH + 4 (20 at defaults)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
instr  in  INSTR_WIDTH  instruction word; fields MSB→LSB: type[2], rd, rs1, rs2, offset, opcode[4]
instr_valid  in  1  instr is valid
instr_ready  out  1  CU can accept an instruction
result2  in  DATA_WIDTH  writeback data (ALU result or data-memory output)
mem_ack  in  1  data memory has completed the access
mem_req  out  1  data memory access request
operand1  out  DATA_WIDTH  R[rs1]
operand2  out  DATA_WIDTH  R[rs2] (std_op) or R[rd] (loadR/storeR)
offset  out  DATA_WIDTH  offset field, zero-extended to DATA_WIDTH
opcode  out  4  ALU opcode
sel1  out  1  1 = ALU result path, 0 = data_out path
sel3  out  1  1 = pass offset to ALU
w_r  out  1  data-memory write enable
retired  out  1  one-cycle pulse when an instruction completes
err  out  1  one-cycle pulse on memory timeout

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; R[i]=i truncated to DATA_WIDTH.
  - operand1/operand2/offset=0, opcode=4'b1111.
  - sel1=sel3=w_r=mem_req=retired=err=0.
  - Reset mid-instruction aborts the instruction with no register write.
- Instruction types: 00 NOP, 01 std_op, 10 loadR, 11 storeR.
- States are one-hot: IDLE, DECODE, EXECUTE, MEM_ACCESS, WRITE_BACK. Any illegal encoding → IDLE.
- IDLE:
  - instr_ready=1 (the only state with ready high).
  - On instr_valid, the instruction is latched internally.
  - NOP: accepted, stay IDLE, no retired pulse. Any other type: → DECODE.
- DECODE: operand/offset/opcode/select outputs registered from the latched instruction → EXECUTE.
  - std_op: sel1=1, sel3=0, w_r=0.
  - loadR: sel1=0, sel3=1, w_r=0.
  - storeR: sel1=1, sel3=1; w_r stays 0 until MEM_ACCESS.
- EXECUTE: outputs held. std_op → WRITE_BACK; loadR/storeR → MEM_ACCESS.
- MEM_ACCESS:
  - mem_req=1. storeR: w_r=1, asserted only in this state.
  - Wait counter counts cycles spent in this state.
  - On mem_ack: mem_req and w_r drop next cycle. loadR → WRITE_BACK. storeR → IDLE with retired=1 and no register write.
  - If MEM_TIMEOUT cycles elapse without mem_ack: err=1 pulse, → IDLE, no register write, no retired.
  - If mem_ack arrives on the same cycle the counter expires, the ack wins.
- WRITE_BACK:
  - R[rd] ← result2, sampled on the edge leaving WRITE_BACK.
  - retired=1 pulse, → IDLE.
- Outputs hold their last values while in IDLE.
- A register written in WRITE_BACK is visible to the very next instruction's DECODE. No forwarding is required because the FSM is not pipelined.
- Latencies, accept to retired: std_op 4 cycles; storeR 4+k cycles; loadR 5+k cycles, where k = mem_ack wait cycles beyond the first.

Decomposition:
- Shared package: instruction type codes; state encodings; field-offset functions derived from REG_BITS/OFFSET_WIDTH; reset opcode 4'b1111.
- One sub-module, cu_regfile: NUM_REGS×DATA_WIDTH, two combinational read ports, one synchronous write port, async active-low reset loading R[i]=i.

Test Plan:
- Reset, then NOP with instr_valid=1 → instr_ready stays 1, state IDLE; retired, mem_req and w_r stay 0; opcode=4'hF.
- std_op rd=1, rs1=2, rs2=3, offset=8'h05, opcode=4'h2 → after DECODE operand1=2, operand2=3, offset=5, sel1=1, sel3=0. Drive result2=8'h05 → R1=5 and retired pulses 4 cycles after accept. A following std_op with rs1=1 shows operand1=5.
- loadR rd=2, rs1=1, offset=8'h10, mem_ack held low 3 cycles, result2=8'hAA → mem_req high for 4 cycles, w_r=0, sel1=0, sel3=1. R2=8'hAA; retired pulses 8 cycles after accept.
- storeR rd=3, rs1=0, mem_ack on the first MEM_ACCESS cycle → w_r=1 for exactly one cycle, operand2=3, no register changes, return to IDLE with retired pulse 4 cycles after accept.
- loadR with MEM_TIMEOUT=4 and mem_ack never asserted → mem_req high for 4 cycles, then err pulse; R unchanged; instr_ready=1 next cycle.
- Assert rst low mid-MEM_ACCESS of a storeR → mem_req and w_r drop immediately (asynchronously); R returns to {0,1,2,3}; operands return to reset values.
